// File: rtl/spi_slave_sync.sv
// SPI slave running entirely in the system clock domain: oversampled pins, all four
// SPI modes, configurable word width and bit order, valid/ready RX and TX streams.
module spi_slave_sync #(
   parameter int unsigned FPGA_CLK  = 12_000_000,
   parameter int unsigned SPI_CLK   = 1_000_000,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned CPOL      = 0,
   parameter int unsigned CPHA      = 0,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              overrun,
   output logic              underrun
);

   localparam int unsigned       CNT_W     = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic              SCLK_IDLE = (CPOL != 0);

   if (64'(FPGA_CLK) < 64'(SPI_CLK) * 64'd8) begin : g_clk_chk
      $error("spi_slave_sync: FPGA_CLK must be at least 8*SPI_CLK");
   end
   if ((DATA_W < 4) || (DATA_W > 32)) begin : g_width_chk
      $error("spi_slave_sync: DATA_W must be in 4..32");
   end

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic sclk_s1, sclk_s2, sclk_d;
   logic cs_s1, cs_s2, cs_d;
   logic mosi_s1, mosi_s2;

   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_shift;
   logic [CNT_W-1:0]  bit_cnt;
   logic              need_load;

   logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic cs_fall, cs_rise;
   logic do_start, do_stop, do_sample, do_shift;
   logic do_load, drive_first, drive_next, word_done;
   logic [DATA_W-1:0] load_word, tx_next, rx_next;

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
   endfunction

   // Two-flop synchronisers plus history flops for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_s1 <= SCLK_IDLE;
         sclk_s2 <= SCLK_IDLE;
         sclk_d  <= SCLK_IDLE;
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_d    <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         cs_s1   <= cs_n;
         cs_s2   <= cs_s1;
         cs_d    <= cs_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sclk_rise   = sclk_s2 & ~sclk_d;
   assign sclk_fall   = ~sclk_s2 & sclk_d;
   assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
   assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
   assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
   assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
   assign cs_fall     = cs_d & ~cs_s2;
   assign cs_rise     = ~cs_d & cs_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cs_fall) state_d = S_ACTIVE;
         S_ACTIVE: if (cs_rise) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Per-state action strobes; a CS rise masks any coincident SCLK edge
   always_comb begin
      do_start  = 1'b0;
      do_stop   = 1'b0;
      do_sample = 1'b0;
      do_shift  = 1'b0;
      case (state_q)
         S_IDLE:   do_start = cs_fall;
         S_ACTIVE: begin
            if (cs_rise) begin
               do_stop = 1'b1;
            end else begin
               do_sample = sample_edge;
               do_shift  = shift_edge;
            end
         end
         default: ;
      endcase
   end

   assign load_word   = tx_ready ? '0 : hold_q;
   assign do_load     = do_start | (do_shift & need_load);
   assign drive_first = do_shift & ~need_load & (CPHA != 0) & (bit_cnt == '0);
   assign drive_next  = do_shift & ~need_load & ~drive_first;
   assign word_done   = do_sample & (bit_cnt == LAST_BIT);
   assign tx_next     = (MSB_FIRST != 0) ? {tx_shift[DATA_W-2:0], 1'b0}
                                         : {1'b0, tx_shift[DATA_W-1:1]};
   assign rx_next     = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_s2}
                                         : {mosi_s2, rx_shift[DATA_W-1:1]};

   // Shift datapath, TX holding register and RX stream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_ready  <= 1'b1;
         overrun   <= 1'b0;
         underrun  <= 1'b0;
         hold_q    <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         need_load <= 1'b0;
      end else begin
         overrun  <= 1'b0;
         underrun <= 1'b0;
         miso_oe  <= (state_d == S_ACTIVE);

         // A load sees the pre-write hold content; a same-cycle write refills it
         if (tx_valid && tx_ready) begin
            hold_q   <= tx_data;
            tx_ready <= 1'b0;
         end else if (do_load) begin
            tx_ready <= 1'b1;
         end

         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         if (word_done) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
            overrun  <= rx_valid & ~rx_ready;
         end

         if (do_stop) begin
            bit_cnt   <= '0;
            miso      <= 1'b0;
            need_load <= 1'b0;
         end else begin
            if (do_load) begin
               tx_shift  <= load_word;
               need_load <= 1'b0;
               underrun  <= tx_ready;
               if (!(do_start && (CPHA != 0))) miso <= first_bit(load_word);
            end else if (drive_first) begin
               miso <= first_bit(tx_shift);
            end else if (drive_next) begin
               tx_shift <= tx_next;
               miso     <= first_bit(tx_next);
            end

            if (do_sample) begin
               rx_shift <= rx_next;
               if (word_done) begin
                  bit_cnt   <= '0;
                  need_load <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: an 8-bit mode-0 instance plus four 16-bit
// LSB-first instances (one per CPOL/CPHA mode) driven by a shared host model.
module tb_spi_slave_sync;

   localparam int HALF = 6;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        h_sclk, h_cs, h_mosi, h_txv, h_rxr;
   logic [31:0] h_txd;
   int          sel;
   int          cfg_w;
   logic        cfg_cpol, cfg_cpha, cfg_lsb;

   int n_checks = 0;
   int n_fail   = 0;
   int ovr_cnt  = 0;
   int und_cnt  = 0;
   int und_snap = 0;
   int u0, o0;
   logic [31:0] r0, r1;

   logic        o_miso, o_oe, o_rxv, o_txr, o_ovr, o_und;
   logic [31:0] o_rxd;

   logic       d_sclk, d_cs_n, d_miso, d_oe, d_rxv, d_txr, d_ovr, d_und;
   logic [7:0] d_rxd;

   assign d_sclk = (sel == 4) ? h_sclk : 1'b0;
   assign d_cs_n = (sel == 4) ? h_cs : 1'b1;

   spi_slave_sync #(
      .FPGA_CLK(12_000_000), .SPI_CLK(1_000_000), .DATA_W(8),
      .CPOL(0), .CPHA(0), .MSB_FIRST(1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk(d_sclk), .cs_n(d_cs_n), .mosi(h_mosi),
      .miso(d_miso), .miso_oe(d_oe), .rx_data(d_rxd), .rx_valid(d_rxv),
      .rx_ready(h_rxr && (sel == 4)), .tx_data(h_txd[7:0]),
      .tx_valid(h_txv && (sel == 4)), .tx_ready(d_txr),
      .overrun(d_ovr), .underrun(d_und)
   );

   logic        m_miso[4], m_oe[4], m_rxv[4], m_txr[4], m_ovr[4], m_und[4];
   logic [15:0] m_rxd[4];

   for (genvar m = 0; m < 4; m++) begin : g_mode
      logic g_sclk, g_cs_n;
      assign g_sclk = (sel == m) ? h_sclk : ((m / 2) != 0);
      assign g_cs_n = (sel == m) ? h_cs : 1'b1;
      spi_slave_sync #(
         .DATA_W(16), .CPOL(m / 2), .CPHA(m % 2), .MSB_FIRST(0)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .sclk(g_sclk), .cs_n(g_cs_n), .mosi(h_mosi),
         .miso(m_miso[m]), .miso_oe(m_oe[m]), .rx_data(m_rxd[m]), .rx_valid(m_rxv[m]),
         .rx_ready(h_rxr && (sel == m)), .tx_data(h_txd[15:0]),
         .tx_valid(h_txv && (sel == m)), .tx_ready(m_txr[m]),
         .overrun(m_ovr[m]), .underrun(m_und[m])
      );
   end

   // Outputs of whichever instance the host is currently talking to
   always_comb begin
      if (sel == 4) begin
         o_miso = d_miso; o_oe = d_oe; o_rxv = d_rxv; o_txr = d_txr;
         o_ovr = d_ovr; o_und = d_und; o_rxd = {24'h0, d_rxd};
      end else begin
         o_miso = m_miso[sel[1:0]]; o_oe = m_oe[sel[1:0]]; o_rxv = m_rxv[sel[1:0]];
         o_txr = m_txr[sel[1:0]]; o_ovr = m_ovr[sel[1:0]]; o_und = m_und[sel[1:0]];
         o_rxd = {16'h0, m_rxd[sel[1:0]]};
      end
   end

   always @(posedge clk) begin
      if (o_ovr) ovr_cnt <= ovr_cnt + 1;
      if (o_und) und_cnt <= und_cnt + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tx_write(input logic [31:0] d);
      h_txd = d;
      h_txv = 1'b1;
      wait_clk(1);
      h_txv = 1'b0;
   endtask

   task automatic rx_accept();
      h_rxr = 1'b1;
      wait_clk(1);
      h_rxr = 1'b0;
   endtask

   task automatic set_mode(input int s, input int w, input logic cpol, input logic cpha,
                           input logic lsb);
      @(negedge clk);
      h_sclk   = cpol;
      sel      = s;
      cfg_w    = w;
      cfg_cpol = cpol;
      cfg_cpha = cpha;
      cfg_lsb  = lsb;
      wait_clk(2);
   endtask

   // Host master: nw words in one CS frame, or abort_bits bits then deselect
   task automatic spi_frame(input int nw, input int abort_bits, input logic [31:0] m0,
                            input logic [31:0] m1, output logic [31:0] r0o,
                            output logic [31:0] r1o);
      logic [31:0] mw, rw;
      int bi, nb;
      r0o = '0;
      r1o = '0;
      nb = (abort_bits > 0) ? abort_bits : cfg_w;
      h_cs = 1'b0;
      wait_clk(HALF);
      for (int w = 0; w < nw; w++) begin
         mw = (w == 0) ? m0 : m1;
         rw = '0;
         for (int i = 0; i < nb; i++) begin
            bi = cfg_lsb ? i : cfg_w - 1 - i;
            if (!cfg_cpha) begin
               h_mosi = mw[bi];
               wait_clk(HALF);
               rw[bi] = o_miso;
               h_sclk = ~cfg_cpol;
               wait_clk(HALF);
            end else begin
               h_sclk = ~cfg_cpol;
               h_mosi = mw[bi];
               wait_clk(HALF);
               rw[bi] = o_miso;
            end
            if (w == nw - 1 && i == nb - 1) und_snap = und_cnt;
            h_sclk = cfg_cpol;
            if (cfg_cpha) wait_clk(HALF);
         end
         if (w == 0) r0o = rw;
         else        r1o = rw;
      end
      if (!cfg_cpha) wait_clk(HALF);
      h_cs = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; h_sclk = 1'b0; h_cs = 1'b1; h_mosi = 1'b0;
      h_txv = 1'b0; h_rxr = 1'b0; h_txd = '0; sel = 4;
      cfg_w = 8; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);

      check("rst_miso", 32'(o_miso), 32'h0);
      check("rst_miso_oe", 32'(o_oe), 32'h0);
      check("rst_rx_data", o_rxd, 32'h0);
      check("rst_rx_valid", 32'(o_rxv), 32'h0);
      check("rst_tx_ready", 32'(o_txr), 32'h1);
      check("rst_overrun", 32'(o_ovr), 32'h0);
      check("rst_underrun", 32'(o_und), 32'h0);

      // Mode 0, 8-bit MSB first
      tx_write(32'hA5);
      check("t1_tx_ready_full", 32'(o_txr), 32'h0);
      u0 = und_cnt;
      spi_frame(1, 0, 32'h3C, 32'h0, r0, r1);
      wait_clk(2 * HALF);
      check("t1_host_rx", r0, 32'hA5);
      check("t1_rx_data", o_rxd, 32'h3C);
      check("t1_rx_valid", 32'(o_rxv), 32'h1);
      check("t1_underrun", 32'(und_snap - u0), 32'h0);
      wait_clk(20);
      check("t1_rx_valid_held", 32'(o_rxv), 32'h1);
      rx_accept();
      wait_clk(1);
      check("t1_rx_valid_clr", 32'(o_rxv), 32'h0);

      // All four modes, 16-bit LSB first
      for (int m = 0; m < 4; m++) begin
         set_mode(m, 16, m[1], m[0], 1'b1);
         tx_write(32'hBEEF);
         spi_frame(1, 0, 32'h1234, 32'h0, r0, r1);
         wait_clk(2 * HALF);
         check($sformatf("t2_m%0d_host_rx", m), r0, 32'hBEEF);
         check($sformatf("t2_m%0d_rx_data", m), o_rxd, 32'h1234);
         check($sformatf("t2_m%0d_rx_valid", m), 32'(o_rxv), 32'h1);
      end

      // Back-to-back words with rx_ready low
      set_mode(4, 8, 1'b0, 1'b0, 1'b0);
      o0 = ovr_cnt;
      spi_frame(2, 0, 32'h11, 32'h22, r0, r1);
      wait_clk(2 * HALF);
      check("t3_overrun_cnt", 32'(ovr_cnt - o0), 32'h1);
      check("t3_rx_data", o_rxd, 32'h22);
      check("t3_rx_valid", 32'(o_rxv), 32'h1);
      rx_accept();

      // Deselect after 5 of 8 bits
      o0 = ovr_cnt;
      spi_frame(1, 5, 32'hE7, 32'h0, r0, r1);
      wait_clk(2);
      check("t4_oe_before_3clk", 32'(o_oe), 32'h1);
      wait_clk(1);
      check("t4_oe_at_3clk", 32'(o_oe), 32'h0);
      wait_clk(10);
      check("t4_no_rx_valid", 32'(o_rxv), 32'h0);
      check("t4_no_overrun", 32'(ovr_cnt - o0), 32'h0);
      spi_frame(1, 0, 32'h81, 32'h0, r0, r1);
      wait_clk(2 * HALF);
      check("t4_rx_data", o_rxd, 32'h81);
      check("t4_rx_valid", 32'(o_rxv), 32'h1);
      rx_accept();

      // No preload: first word underruns, a mid-frame write feeds the second
      check("t5_tx_ready", 32'(o_txr), 32'h1);
      u0 = und_cnt;
      fork
         spi_frame(2, 0, 32'h13, 32'h57, r0, r1);
         begin
            wait_clk(30);
            tx_write(32'h5A);
         end
      join
      wait_clk(2 * HALF);
      check("t5_underrun_cnt", 32'(und_snap - u0), 32'h1);
      check("t5_host_rx0", r0, 32'h00);
      check("t5_host_rx1", r1, 32'h5A);
      check("t5_rx_data", o_rxd, 32'h57);

      // Asynchronous reset in the middle of a frame
      tx_write(32'hFF);
      h_cs = 1'b0;
      wait_clk(HALF);
      tx_write(32'h96);
      h_sclk = 1'b1;
      wait_clk(HALF);
      h_sclk = 1'b0;
      wait_clk(HALF);
      h_sclk = 1'b1;
      wait_clk(4);
      check("t6_pre_oe", 32'(o_oe), 32'h1);
      check("t6_pre_miso", 32'(o_miso), 32'h1);
      check("t6_pre_tx_ready", 32'(o_txr), 32'h0);
      check("t6_pre_rx_valid", 32'(o_rxv), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_miso", 32'(o_miso), 32'h0);
      check("t6_rst_oe", 32'(o_oe), 32'h0);
      check("t6_rst_rx_valid", 32'(o_rxv), 32'h0);
      check("t6_rst_rx_data", o_rxd, 32'h0);
      check("t6_rst_tx_ready", 32'(o_txr), 32'h1);
      h_cs = 1'b1;
      h_sclk = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);
      tx_write(32'h3C);
      spi_frame(1, 0, 32'h69, 32'h0, r0, r1);
      wait_clk(2 * HALF);
      check("t6_host_rx", r0, 32'h3C);
      check("t6_rx_data", o_rxd, 32'h69);
      check("t6_rx_valid", 32'(o_rxv), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised SPI slave that runs entirely in the FPGA system clock domain. SCLK, CS_N and MOSI are oversampled and synchronised, and all four SPI modes are supported. Word width and bit order are configurable. Received words are delivered on a valid/ready stream, and words to transmit are accepted on a second valid/ready stream. It replaces the SCLK-clocked slave at the SPI pin boundary, between the external MCU and the on-chip bus master.

## Interface
- FPGA_CLK, 12_000_000: system clock frequency in Hz.
- SPI_CLK, 1_000_000: maximum SCLK frequency in Hz. Elaboration fails unless FPGA_CLK >= 8*SPI_CLK.
- DATA_W, 8: bits per SPI word, 4..32.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first; 0 = LSB first.

Ports (name, direction, width, meaning):
- clk  in  1  system clock. One clock only; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock pin, asynchronous.
- cs_n  in  1  SPI chip select pin, active low, asynchronous.
- mosi  in  1  SPI data in, asynchronous.
- miso  out  1  SPI data out.
- miso_oe  out  1  MISO output enable; high while selected.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX holding register is empty.
- overrun  out  1  one-cycle pulse: a word completed while rx_valid was still high.
- underrun  out  1  one-cycle pulse: a word started with the TX holding register empty.

## Operation
- **Synchronisation and edge detect.** sclk, cs_n and mosi each pass through a 2-flop synchroniser, plus one history flop for sclk and cs_n. Edges are detected from the synchronised copies only.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge = the other edge.
- **IDLE state.** Entered when synchronised cs_n is high.
  - bit_cnt = 0; miso_oe = 0; miso = 0.
  - SCLK and MOSI activity is ignored.
- **IDLE -> ACTIVE** on synchronised cs_n falling. Word load:
  - tx_shift <= hold if hold is full, else 0 with an underrun pulse.
  - hold is emptied, so tx_ready goes to 1.
  - CPHA=0: miso <= first bit of tx_shift in the same cycle.
- **Sample edge in ACTIVE.**
  - Shift synchronised mosi into rx_shift in MSB_FIRST order; bit_cnt += 1.
  - When bit_cnt reaches DATA_W-1 (the last bit): rx_data <= completed word, rx_valid <= 1, bit_cnt <= 0.
    - If rx_valid was already 1 and not being accepted that cycle, overrun pulses. rx_data is overwritten with the new word.
- **Shift edge in ACTIVE.**
  - CPHA=0: miso <= next bit. On the trailing edge of the last bit, perform a word load and drive the first bit of the new word.
  - CPHA=1: the first leading edge of each word drives the first bit; later leading edges drive the next bit. The word load happens at the first leading edge of each word after the previous word completed.
- **ACTIVE -> IDLE** on synchronised cs_n rising, at any bit position.
  - The partial RX word is discarded: no rx_valid, no overrun.
  - Any loaded tx_shift word is discarded; the hold register is unaffected.
- **TX holding register.** One entry.
  - Write on tx_valid && tx_ready; tx_ready <= 0 on the next cycle.
  - A word load and a write in the same cycle: the load takes the old content (or underruns), and the write fills the hold.
- **RX stream.** rx_valid clears on rx_valid && rx_ready. A completion in the same cycle as an accept keeps rx_valid = 1 with the new data, and no overrun.

## Timing
- Reset values: miso = 0, miso_oe = 0, rx_data = 0, rx_valid = 0, tx_ready = 1, overrun = 0, underrun = 0, state IDLE, bit_cnt = 0, hold empty.
- Pin-to-action latency: a pin transition set up before clk edge k is acted on at edge k+2, with registered outputs visible after k+2.
  - rx_valid rises 3 clk edges after the final sample-edge transition.
  - miso changes 3 clk edges after the shift edge.
- miso_oe rises and falls 3 clk edges after the corresponding cs_n transition.
- SCLK high and low phases must each be >= 4 clk periods, guaranteed by FPGA_CLK >= 8*SPI_CLK.
- CS_N setup to the first SCLK edge and hold after the last edge must each be >= 4 clk periods.
- Back-to-back words within one CS frame need no gap; the host may keep SCLK running.

## Test plan
- **Mode 0, DATA_W=8, MSB_FIRST.** Preload tx_data=0xA5, then clock mosi=0x3C at SPI_CLK.
  - rx_data=0x3C with rx_valid pulse held until rx_ready.
  - The miso bitstream sampled by the host reads 0xA5.
  - underrun=0.
- **All four CPOL/CPHA modes at DATA_W=16, MSB_FIRST=0.** Host sends 0x1234 with tx preloaded 0xBEEF.
  - Every mode gives rx_data=0x1234 and host receives 0xBEEF.
- **Back-to-back frame, rx_ready held low.** Send 0x11 then 0x22 in one CS frame.
  - overrun pulses once.
  - rx_data=0x22.
- **CS_N deasserted after 5 of 8 bits.**
  - No rx_valid; miso_oe=0 within 3 clk.
  - The next full frame sends 0x81 and rx_data=0x81.
- **No tx preload.** Run a frame.
  - underrun pulses once at CS fall; host receives 0x00.
  - tx_valid with 0x5A during the frame makes the next word 0x5A.
- **rst_n asserted mid-frame.** All outputs return to reset values immediately, asynchronously; the next frame works normally.
